// File: rtl/apb_req_arbiter_pkg.sv
// Shared types and helpers for the APB request arbiter: FSM state encoding,
// default widths and the round-robin pick function used by the picker.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_arb_state_e;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_ADDR_W  = 9;
    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_TIMEOUT = 16;

    // The pick helper works on the largest supported requester count; smaller
    // configurations zero-extend their request vector into it.
    localparam int unsigned MAX_REQ = 8;

    typedef struct packed {
        logic       any;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of req[num-1:0], searching upward from ptr+1 and wrapping.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0]         ptr,
                                         input logic [3:0]         num);
        logic [3:0] idx;
        rr_pick_t   res;
        res.any = 1'b0;
        res.idx = 3'd0;
        for (int off = 1; off <= int'(MAX_REQ); off++) begin
            idx = {1'b0, ptr} + 4'(off);
            if (idx >= num) begin
                idx = idx - num;
            end else begin
                idx = idx;
            end
            if ((4'(off) <= num) && !res.any && req[idx[2:0]]) begin
                res.any = 1'b1;
                res.idx = idx[2:0];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_req_arbiter_if.sv
// APB master-side bus bundle. The arbiter drives it through the master
// modport; the downstream slave pair (or a bench) uses the slave modport.
interface apb_req_arbiter_if
    import apb_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) ();

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_req_arbiter_rr_picker.sv
// Combinational round-robin picker: given the pending request vector and the
// index of the last granted requester, returns the next requester to serve.
module apb_rr_picker
    import apb_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [MAX_REQ-1:0] w_req_ext;
    logic [2:0]         w_ptr_ext;
    rr_pick_t           w_pick;
    logic               w_unused_idx;

    // widen to the helper's fixed width, pick, and form the one-hot grant
    always_comb begin
        w_req_ext              = {MAX_REQ{1'b0}};
        w_req_ext[NUM_REQ-1:0] = i_req;
        w_ptr_ext              = 3'd0;
        w_ptr_ext[IDX_W-1:0]   = i_ptr;
        w_pick                 = rr_pick(w_req_ext, w_ptr_ext, 4'(NUM_REQ));
        o_any                  = w_pick.any;
        o_idx                  = w_pick.idx[IDX_W-1:0];
        if (w_pick.any) begin
            o_grant = NUM_REQ'(1'b1) << o_idx;
        end else begin
            o_grant = {NUM_REQ{1'b0}};
        end
    end

    // upper index bits are always zero for small configurations
    assign w_unused_idx = ^w_pick.idx;

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master port between NUM_REQ requesters. Round-robin grant in
// IDLE, then SETUP and ACCESS phases; ACCESS waits for PREADY and aborts with
// an error after TIMEOUT cycles. The completion (data or error) is returned to
// the owning requester as a registered one-cycle pulse.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      busy,
    apb_req_arbiter_if.master         apb
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    apb_arb_state_e     r_state;
    apb_arb_state_e     w_state_nxt;

    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_gidx;
    logic [CNT_W-1:0]   r_cnt;

    logic               r_write;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_psel;
    logic               r_penable;
    logic               r_busy;

    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_rdata;
    logic               r_rsp_err;

    logic [NUM_REQ-1:0] w_pick_grant;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;

    logic               w_accept;
    logic               w_done;
    logic               w_abort;
    logic [NUM_REQ-1:0] w_req_ready;

    logic               w_sel_write;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;

    apb_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // payload of the requester the picker is pointing at
    always_comb begin
        w_sel_write = req_write[w_pick_idx];
        w_sel_addr  = req_addr[int'(w_pick_idx)*int'(ADDR_W) +: ADDR_W];
        w_sel_wdata = req_wdata[int'(w_pick_idx)*int'(DATA_W) +: DATA_W];
    end

    // next-state and phase strobes
    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = {NUM_REQ{1'b0}};
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_req_ready = w_pick_grant;
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SETUP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (apb.PREADY) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // capture, APB drive, timeout counter and response registers
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_ptr       <= IDX_W'(NUM_REQ - 1);
            r_gidx      <= {IDX_W{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_write     <= 1'b0;
            r_addr      <= {ADDR_W{1'b0}};
            r_wdata     <= {DATA_W{1'b0}};
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_valid <= {NUM_REQ{1'b0}};
            r_rsp_rdata <= {DATA_W{1'b0}};
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= {NUM_REQ{1'b0}};
            r_rsp_rdata <= {DATA_W{1'b0}};
            r_rsp_err   <= 1'b0;
            r_busy      <= (w_state_nxt != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_write   <= w_sel_write;
                        r_addr    <= w_sel_addr;
                        // reads present zero on PWDATA
                        r_wdata   <= w_sel_write ? w_sel_wdata : {DATA_W{1'b0}};
                        r_gidx    <= w_pick_idx;
                        r_ptr     <= w_pick_idx;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                    end else begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_cnt     <= {CNT_W{1'b0}};
                end
                ST_ACCESS: begin
                    if (w_done) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= NUM_REQ'(1'b1) << r_gidx;
                        r_rsp_err   <= apb.PSLVERR;
                        r_rsp_rdata <= r_write ? {DATA_W{1'b0}} : apb.PRDATA;
                    end else if (w_abort) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= NUM_REQ'(1'b1) << r_gidx;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= {DATA_W{1'b0}};
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1'b1);
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = w_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign busy        = r_busy;

    assign apb.PSEL    = r_psel;
    assign apb.PENABLE = r_penable;
    assign apb.PWRITE  = r_write;
    assign apb.PADDR   = r_addr;
    assign apb.PWDATA  = r_wdata;

endmodule
